// File: rtl/peri_spi_multi_if.sv
// -----------------------------------------------------------------------------
// peri_spi_multi_if
// Peripheral-bus interface for the multi-sensor SPI master.
//   we_i    : write enable, one cycle per write (master -> slave)
//   addr_i  : register select (master -> slave)
//   data_i  : write data (master -> slave)
//   data_o  : read data, combinational on addr_i (slave -> master)
// -----------------------------------------------------------------------------
interface peri_spi_multi_if;
   logic        we_i;
   logic [1:0]  addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;

   modport master (output we_i, output addr_i, output data_i, input data_o);
   modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/peri_spi_multi.sv
// -----------------------------------------------------------------------------
// peri_spi_multi
// Memory-mapped SPI master (mode 0, MSB first) for external sensors.
// One command byte followed by 1..4 read bytes per frame, N_CS chip selects,
// programmable SCLK half-period and continuous auto-repeat with a sample count.
//
// Ports:
//   clk_i     : system clock
//   reset_ni  : asynchronous active-low reset
//   bus       : register bus (we_i, addr_i, data_i, data_o)
//   miso_i    : SPI MISO
//   sclk_o    : SPI clock (idle low)
//   mosi_o    : SPI MOSI
//   cs_no     : chip selects, active low
//   done_o    : mirror of STATUS.done (interrupt)
//
// Registers: 0 CTRL, 1 TX, 2 RX, 3 STATUS.
// -----------------------------------------------------------------------------
module peri_spi_multi #(
   parameter int unsigned N_CS    = 4,
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned GAP_CYC = 16
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   peri_spi_multi_if.slave    bus,
   input  logic               miso_i,
   output logic               sclk_o,
   output logic               mosi_o,
   output logic [N_CS-1:0]    cs_no,
   output logic               done_o
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_DONE,
      ST_GAP
   } state_t;

   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_M1 = 16'(GAP_CYC - 1);

   // Programmer-visible registers
   logic        cont;
   logic [3:0]  cs_sel;
   logic [1:0]  nb;
   logic [7:0]  tx;
   logic [31:0] rx;
   logic        done;
   logic [15:0] count;

   // Frame engine
   state_t      state;
   logic [1:0]  sh_nb;
   logic [7:0]  tx_sh;
   logic [31:0] rx_sh;
   logic [15:0] div_cnt;
   logic [15:0] gap_cnt;
   logic [5:0]  bit_cnt;
   logic [2:0]  nb_plus2;
   logic [5:0]  frame_bits_m1;

   logic        wr_ctrl;
   logic        wr_tx;
   logic        wr_stat;
   logic        start_req;
   logic [3:0]  sel_in;
   logic        busy;
   logic [31:0] rdata;
   logic        unused_bits;

   function automatic logic [3:0] clamp_sel(input logic [3:0] s);
      if (32'(s) >= N_CS) return 4'(N_CS - 1);
      return s;
   endfunction

   function automatic logic [N_CS-1:0] cs_mask(input logic [3:0] idx);
      logic [N_CS-1:0] m;
      m = '1;
      for (int unsigned i = 0; i < N_CS; i++) begin
         m[i] = (4'(i) != idx);
      end
      return m;
   endfunction

   function automatic logic [31:0] rx_mask(input logic [1:0] n);
      case (n)
         2'd0:    return 32'h0000_00FF;
         2'd1:    return 32'h0000_FFFF;
         2'd2:    return 32'h00FF_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   assign wr_ctrl   = bus.we_i && (bus.addr_i == 2'd0);
   assign wr_tx     = bus.we_i && (bus.addr_i == 2'd1);
   assign wr_stat   = bus.we_i && (bus.addr_i == 2'd3);
   assign start_req = wr_ctrl && bus.data_i[0] && (state == ST_IDLE);
   assign sel_in    = clamp_sel(bus.data_i[7:4]);
   assign busy      = (state != ST_IDLE);
   assign done_o    = done;

   assign nb_plus2      = 3'(sh_nb) + 3'd2;
   assign frame_bits_m1 = {nb_plus2, 3'b000} - 6'd1;

   assign unused_bits = ^{bus.data_i[31:10], bus.data_i[3:2]};

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cont   <= 1'b0;
         cs_sel <= '0;
         nb     <= '0;
         tx     <= '0;
      end else begin
         if (wr_ctrl) begin
            cont   <= bus.data_i[1];
            cs_sel <= sel_in;
            nb     <= bus.data_i[9:8];
         end
         if (wr_tx) begin
            tx <= bus.data_i[7:0];
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   // cs_no doubles as the chip-select shadow: it is loaded once per frame at
   // SETUP entry, so later CTRL writes cannot disturb a running frame.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state   <= ST_IDLE;
         sh_nb   <= '0;
         tx_sh   <= '0;
         rx_sh   <= '0;
         div_cnt <= '0;
         gap_cnt <= '0;
         bit_cnt <= '0;
         sclk_o  <= 1'b0;
         mosi_o  <= 1'b0;
         cs_no   <= '1;
         rx      <= '0;
         done    <= 1'b0;
         count   <= '0;
      end else begin
         // Clear first so a DONE-cycle set below takes priority.
         if (wr_stat && bus.data_i[1]) begin
            done <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (start_req) begin
                  state   <= ST_SETUP;
                  sh_nb   <= bus.data_i[9:8];
                  tx_sh   <= tx;
                  rx_sh   <= '0;
                  div_cnt <= DIV_M1;
                  sclk_o  <= 1'b0;
                  mosi_o  <= tx[7];
                  cs_no   <= cs_mask(sel_in);
               end
            end

            ST_SETUP: begin
               if (div_cnt == '0) begin
                  state   <= ST_SHIFT;
                  div_cnt <= DIV_M1;
                  bit_cnt <= frame_bits_m1;
               end else begin
                  div_cnt <= div_cnt - 16'd1;
               end
            end

            ST_SHIFT: begin
               if (div_cnt != '0) begin
                  div_cnt <= div_cnt - 16'd1;
               end else begin
                  div_cnt <= DIV_M1;
                  if (!sclk_o) begin
                     // Rising edge: MISO captured on this very clock.
                     sclk_o <= 1'b1;
                     rx_sh  <= {rx_sh[30:0], miso_i};
                  end else begin
                     sclk_o <= 1'b0;
                     if (bit_cnt == '0) begin
                        state  <= ST_HOLD;
                        mosi_o <= 1'b0;
                     end else begin
                        bit_cnt <= bit_cnt - 6'd1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                        mosi_o  <= tx_sh[6];
                     end
                  end
               end
            end

            ST_HOLD: begin
               if (div_cnt == '0) begin
                  state <= ST_DONE;
                  cs_no <= '1;
               end else begin
                  div_cnt <= div_cnt - 16'd1;
               end
            end

            ST_DONE: begin
               // Command-byte bits still sit above the read bytes for nb<3.
               rx    <= rx_sh & rx_mask(sh_nb);
               done  <= 1'b1;
               count <= count + 16'd1;
               if (cont) begin
                  state   <= ST_GAP;
                  gap_cnt <= GAP_M1;
               end else begin
                  state <= ST_IDLE;
               end
            end

            ST_GAP: begin
               if (gap_cnt == '0) begin
                  state   <= ST_SETUP;
                  sh_nb   <= nb;
                  tx_sh   <= tx;
                  rx_sh   <= '0;
                  div_cnt <= DIV_M1;
                  sclk_o  <= 1'b0;
                  mosi_o  <= tx[7];
                  cs_no   <= cs_mask(cs_sel);
               end else begin
                  gap_cnt <= gap_cnt - 16'd1;
               end
            end

            default: begin
               state  <= ST_IDLE;
               sclk_o <= 1'b0;
               mosi_o <= 1'b0;
               cs_no  <= '1;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- read mux
   always_comb begin
      rdata = '0;
      case (bus.addr_i)
         2'd0:    rdata = {22'd0, nb, cs_sel, 2'b00, cont, 1'b0};
         2'd1:    rdata = {24'd0, tx};
         2'd2:    rdata = rx;
         default: rdata = {count, 14'd0, done, busy};
      endcase
   end

   assign bus.data_o = rdata;

endmodule

// File: tb/tb_peri_spi_multi.sv
// -----------------------------------------------------------------------------
// tb_peri_spi_multi
// Directed bench for peri_spi_multi with a mode-0 SPI slave model, a register
// read scoreboard and a frame scoreboard (CS pattern, bit count, MOSI, gaps).
// -----------------------------------------------------------------------------
module tb_peri_spi_multi;
   localparam int N_CS    = 4;
   localparam int CLK_DIV = 2;
   localparam int GAP_CYC = 16;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            miso = 1'b0;
   logic            sclk;
   logic            mosi;
   logic [N_CS-1:0] cs_n;
   logic            done;

   peri_spi_multi_if bus ();

   peri_spi_multi #(.N_CS(N_CS), .CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
      .clk_i   (clk),
      .reset_ni(rst_n),
      .bus     (bus),
      .miso_i  (miso),
      .sclk_o  (sclk),
      .mosi_o  (mosi),
      .cs_no   (cs_n),
      .done_o  (done)
   );

   always #50 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------- read scoreboard
   typedef struct {
      string       name;
      logic [31:0] exp;
   } rd_exp_t;

   rd_exp_t rd_q[$];
   logic    rd_req = 1'b0;

   always @(negedge clk) begin
      if (rd_req) begin
         rd_exp_t r;
         if (rd_q.size() == 0) begin
            chk("rd_q_underflow", 64'd1, 64'd0);
         end else begin
            r = rd_q.pop_front();
            chk(r.name, 64'(bus.data_o), 64'(r.exp));
         end
      end
   end

   // --------------------------------------------------------- frame scoreboard
   typedef struct {
      logic [3:0]  cs;
      int          nbits;
      logic [63:0] mosi;
      int          gap;   // 0 = not checked
   } fr_exp_t;

   fr_exp_t     fr_q[$];
   int          frames_done = 0;
   logic        in_frame = 1'b0;
   logic [3:0]  cs_pat;
   logic        cs_err;
   int          nbits_obs;
   logic [63:0] mosi_obs;
   int          gap_cnt = 0;
   int          gap_at_start;
   logic        mon_prev_sclk = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame      = 1'b0;
         gap_cnt       = 0;
      end else if (cs_n != 4'hF) begin
         if (!in_frame) begin
            in_frame     = 1'b1;
            cs_pat       = cs_n;
            cs_err       = 1'b0;
            nbits_obs    = 0;
            mosi_obs     = '0;
            gap_at_start = gap_cnt;
         end else if (cs_n != cs_pat) begin
            cs_err = 1'b1;
         end
         if (sclk && !mon_prev_sclk) begin
            mosi_obs = {mosi_obs[62:0], mosi};
            nbits_obs++;
         end
      end else begin
         if (in_frame) begin
            fr_exp_t f;
            in_frame = 1'b0;
            frames_done++;
            if (fr_q.size() == 0) begin
               chk("frame_unexpected", 64'd1, 64'd0);
            end else begin
               f = fr_q.pop_front();
               chk("frame_cs", 64'(cs_err ? 4'h0 : cs_pat), 64'(f.cs));
               chk("frame_bits", 64'(nbits_obs), 64'(f.nbits));
               chk("frame_mosi", mosi_obs, f.mosi);
               if (f.gap != 0) chk("frame_gap", 64'(gap_at_start), 64'(f.gap));
            end
            gap_cnt = 0;
         end
         gap_cnt++;
      end
      mon_prev_sclk = sclk;
   end

   // ---------------------------------------------------------- SPI slave model
   logic [31:0] slv_q[$];
   logic [63:0] slv_sh = '0;
   logic        slv_prev_act = 1'b0;
   logic        slv_prev_sclk = 1'b0;

   always @(negedge clk) begin
      logic act;
      act = (cs_n != 4'hF);
      if (act && !slv_prev_act) begin
         // Command byte slot is filled with ones; the master must drop it.
         slv_sh = {8'hFF, (slv_q.size() != 0) ? slv_q.pop_front() : 32'h0, 24'h0};
         miso   = slv_sh[63];
      end else if (act && slv_prev_sclk && !sclk) begin
         slv_sh = {slv_sh[62:0], 1'b0};
         miso   = slv_sh[63];
      end
      slv_prev_act  = act;
      slv_prev_sclk = sclk;
   end

   // ---------------------------------------------------------- stimulus tasks
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.we_i   = 1'b1;
      bus.addr_i = a;
      bus.data_i = d;
      @(posedge clk); #1;
      bus.we_i   = 1'b0;
      bus.data_i = '0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] e, input string n);
      rd_exp_t t;
      t.name = n;
      t.exp  = e;
      rd_q.push_back(t);
      bus.addr_i = a;
      rd_req = 1'b1;
      @(posedge clk); #1;
      rd_req = 1'b0;
   endtask

   task automatic push_frame(input logic [3:0] c, input int nbits,
                             input logic [7:0] txb, input int gap);
      fr_exp_t f;
      f.cs    = c;
      f.nbits = nbits;
      f.mosi  = 64'(txb) << (nbits - 8);
      f.gap   = gap;
      fr_q.push_back(f);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input string n);
      bit ok;
      ok = 1'b0;
      bus.addr_i = 2'd3;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (!bus.data_o[0]) begin
            ok = 1'b1;
            break;
         end
      end
      chk(n, 64'(ok), 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_frames(input int target, input string n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (frames_done >= target) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk(n, 64'(ok), 64'd1);
   endtask

   task automatic wait_cs_active(input string n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (cs_n != 4'hF) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk(n, 64'(ok), 64'd1);
   endtask

   // ---------------------------------------------------------- main sequence
   initial begin
      int base;
      int busy_cyc;
      bus.we_i   = 1'b0;
      bus.addr_i = '0;
      bus.data_i = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset state
      chk("rst_cs", 64'(cs_n), 64'hF);
      chk("rst_sclk", 64'(sclk), 64'd0);
      chk("rst_mosi", 64'(mosi), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      rd(2'd0, 32'h0, "rst_ctrl");
      rd(2'd1, 32'h0, "rst_tx");
      rd(2'd2, 32'h0, "rst_rx");
      rd(2'd3, 32'h0, "rst_status");

      // Single frame: cs 1, two read bytes
      wr(2'd1, 32'h8F);
      slv_q.push_back(32'hA53C_0000);
      push_frame(4'b1101, 24, 8'h8F, 0);
      wr(2'd0, 32'h111);
      bus.addr_i = 2'd3;
      busy_cyc = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (bus.data_o[0]) busy_cyc++;
         else break;
      end
      chk("busy_cycles", 64'(busy_cyc), 64'd101);
      @(posedge clk); #1;
      rd(2'd2, 32'h0000_A53C, "single_rx");
      rd(2'd3, 32'h0001_0002, "single_status");
      chk("single_done_o", 64'(done), 64'd1);
      rd(2'd0, 32'h0000_0110, "single_ctrl");

      // Continuous mode, cont cleared during frame 3
      do_reset();
      wr(2'd1, 32'h8F);
      slv_q.push_back(32'h1100_0000);
      slv_q.push_back(32'h2200_0000);
      slv_q.push_back(32'h3300_0000);
      push_frame(4'b1011, 16, 8'h8F, 0);
      push_frame(4'b1011, 16, 8'h8F, GAP_CYC + 1);
      push_frame(4'b1011, 16, 8'h8F, GAP_CYC + 1);
      base = frames_done;
      wr(2'd0, 32'h23);
      wait_frames(base + 2, "cont_two_frames");
      wait_cs_active("cont_third_start");
      wr(2'd0, 32'h20);
      wait_idle("cont_idle");
      repeat (200) @(posedge clk);
      #1;
      chk("cont_frame_count", 64'(frames_done - base), 64'd3);
      rd(2'd2, 32'h33, "cont_rx");
      rd(2'd3, 32'h0003_0002, "cont_status");

      // cs_sel clamp and start while busy
      do_reset();
      wr(2'd1, 32'h5A);
      slv_q.push_back(32'hC300_0000);
      push_frame(4'b0111, 16, 8'h5A, 0);
      base = frames_done;
      wr(2'd0, 32'hF1);
      repeat (5) @(posedge clk);
      #1;
      chk("clamp_cs_live", 64'(cs_n), 64'b0111);
      wr(2'd0, 32'hF1);
      wait_idle("clamp_idle");
      repeat (150) @(posedge clk);
      #1;
      chk("clamp_frame_count", 64'(frames_done - base), 64'd1);
      rd(2'd2, 32'hC3, "clamp_rx");
      rd(2'd0, 32'h30, "clamp_ctrl");
      rd(2'd3, 32'h0001_0002, "clamp_status");

      // Reset in the middle of SHIFT
      do_reset();
      wr(2'd1, 32'h8F);
      slv_q.push_back(32'hDEAD_BEEF);
      wr(2'd0, 32'h301);
      base = frames_done;
      repeat (20) @(posedge clk);
      #1;
      chk("midrst_active", 64'(cs_n), 64'b1110);
      rst_n = 1'b0;
      #1;
      chk("midrst_cs", 64'(cs_n), 64'hF);
      chk("midrst_sclk", 64'(sclk), 64'd0);
      chk("midrst_mosi", 64'(mosi), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      rd(2'd2, 32'h0, "midrst_rx");
      rd(2'd3, 32'h0, "midrst_status");
      repeat (200) @(posedge clk);
      #1;
      chk("midrst_no_frame", 64'(frames_done - base), 64'd0);

      // Done-clear coinciding with DONE, then a later clear
      do_reset();
      wr(2'd1, 32'h01);
      slv_q.push_back(32'h7700_0000);
      push_frame(4'b1110, 16, 8'h01, 0);
      wr(2'd0, 32'h001);
      repeat (68) @(posedge clk);
      #1;
      wr(2'd3, 32'h2);
      rd(2'd3, 32'h0001_0002, "clr_race_status");
      chk("clr_race_done_o", 64'(done), 64'd1);
      wr(2'd3, 32'h2);
      rd(2'd3, 32'h0001_0000, "clr_status");
      chk("clr_done_o", 64'(done), 64'd0);
      rd(2'd2, 32'h77, "clr_rx");

      repeat (5) @(posedge clk);
      #1;
      chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
      chk("fr_q_empty", 64'(fr_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #(100 * 60000);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
